// File: rtl/sintable_pkg.sv
// Shared constants for the sintable phase generator.
//   REG_*  : configuration register addresses
//   state_e: generator state encoding (ST_IDLE, ST_TONE, ST_SWEEP)
//   DEF_PW / DEF_OW: default accumulator and output phase widths
package sintable_pkg;

  localparam int unsigned DEF_PW = 24;
  localparam int unsigned DEF_OW = 8;

  localparam logic [1:0] REG_FSTART = 2'd0;
  localparam logic [1:0] REG_FSTOP  = 2'd1;
  localparam logic [1:0] REG_FSTEP  = 2'd2;
  localparam logic [1:0] REG_POFS   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TONE  = 2'd1,
    ST_SWEEP = 2'd2
  } state_e;

endpackage

// File: rtl/sintable_phase_gen_if.sv
// Phase interface between the phase generator (master) and the sintable
// lookup (slave).
//   phase      : table address
//   valid      : one-cycle strobe qualifying phase
//   wrap       : accumulator carry-out of the emitted sample
//   sweep_done : pulse when the chirp reaches its stop frequency
interface sintable_phase_gen_if
  import sintable_pkg::*;
#(
  parameter int unsigned OW = DEF_OW
) ();

  logic [OW-1:0] phase;
  logic          valid;
  logic          wrap;
  logic          sweep_done;

  modport master (output phase, valid, wrap, sweep_done);
  modport slave  (input  phase, valid, wrap, sweep_done);

endinterface

// File: rtl/sintable_phase_acc.sv
// Phase accumulator: PW-bit accumulator with carry, phase offset add and
// truncation to the OW-bit table address.
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the accumulator (start/restart)
//   step       : accepted sample; emit phase and advance by freq
//   freq, pofs : frequency word and phase offset
//   phase      : registered top OW bits of acc + pofs
//   valid, wrap: registered sample strobe and carry-out
module sintable_phase_acc
  import sintable_pkg::*;
#(
  parameter int unsigned PW = DEF_PW,
  parameter int unsigned OW = DEF_OW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          step,
  input  logic [PW-1:0] freq,
  input  logic [PW-1:0] pofs,
  output logic [OW-1:0] phase,
  output logic          valid,
  output logic          wrap
);

  logic [PW-1:0] acc_q;
  logic [PW-1:0] sum_c;

  // Offset is applied to the emitted phase only, never stored.
  assign sum_c = acc_q + pofs;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      phase <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      valid <= 1'b0;
      wrap  <= 1'b0;
      if (clear) begin
        acc_q <= '0;
      end else if (step) begin
        phase          <= OW'(sum_c >> (PW - OW));
        valid          <= 1'b1;
        {wrap, acc_q}  <= {1'b0, acc_q} + {1'b0, freq};
      end
    end
  end

endmodule

// File: rtl/sintable_phase_gen.sv
// Numerically controlled phase generator with optional linear chirp,
// producer side of the sintable phase interface.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_ce           : sample strobe
//   i_cfg_*        : register write port (FSTART/FSTOP/FSTEP/POFS)
//   i_start/i_stop : start (restart) and halt generation; stop wins
//   phase_if       : phase/valid/wrap/sweep_done outputs (master)
//   o_busy         : high in TONE or SWEEP
module sintable_phase_gen
  import sintable_pkg::*;
#(
  parameter int unsigned PW = DEF_PW,
  parameter int unsigned OW = DEF_OW
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_ce,
  input  logic                        i_cfg_wr,
  input  logic [1:0]                  i_cfg_addr,
  input  logic [PW-1:0]               i_cfg_data,
  input  logic                        i_start,
  input  logic                        i_stop,
  sintable_phase_gen_if.master        phase_if,
  output logic                        o_busy
);

  state_e        state_q, state_d;
  logic [PW-1:0] fstart_q, fstop_q, fstep_q, pofs_q;
  logic [PW-1:0] freq_q, freq_d;
  logic          done_q, done_d;
  logic          step_c, clear_c;
  logic [PW:0]   nf_c;

  logic [OW-1:0] phase_w;
  logic          valid_w, wrap_w;

  // Configuration registers, writable in any state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fstart_q <= '0;
      fstop_q  <= '0;
      fstep_q  <= '0;
      pofs_q   <= '0;
    end else if (i_cfg_wr) begin
      case (i_cfg_addr)
        REG_FSTART: fstart_q <= i_cfg_data;
        REG_FSTOP:  fstop_q  <= i_cfg_data;
        REG_FSTEP:  fstep_q  <= i_cfg_data;
        default:    pofs_q   <= i_cfg_data;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, frequency update and sample acceptance.
  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    done_d  = 1'b0;
    step_c  = 1'b0;
    clear_c = 1'b0;
    nf_c    = {1'b0, freq_q} + {1'b0, fstep_q};
    if (i_stop) begin
      state_d = ST_IDLE;
    end else if (i_start) begin
      clear_c = 1'b1;
      freq_d  = fstart_q;
      state_d = (fstep_q != '0 && fstart_q < fstop_q) ? ST_SWEEP : ST_TONE;
    end else if (i_ce && state_q != ST_IDLE) begin
      step_c = 1'b1;
      if (state_q == ST_SWEEP) begin
        // Clamp at FSTOP; carry into bit PW also counts as reaching it.
        if (nf_c >= {1'b0, fstop_q}) begin
          freq_d  = fstop_q;
          state_d = ST_TONE;
          done_d  = 1'b1;
        end else begin
          freq_d = PW'(nf_c);
        end
      end
    end
  end

  // Frequency word, sweep-done pulse and busy flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      freq_q <= '0;
      done_q <= 1'b0;
      o_busy <= 1'b0;
    end else begin
      freq_q <= freq_d;
      done_q <= done_d;
      o_busy <= (state_d != ST_IDLE);
    end
  end

  // The sample uses the frequency in effect before this cycle's update.
  sintable_phase_acc #(
    .PW (PW),
    .OW (OW)
  ) u_acc (
    .clk   (i_clk),
    .reset (i_reset),
    .clear (clear_c),
    .step  (step_c),
    .freq  (freq_q),
    .pofs  (pofs_q),
    .phase (phase_w),
    .valid (valid_w),
    .wrap  (wrap_w)
  );

  assign phase_if.phase      = phase_w;
  assign phase_if.valid      = valid_w;
  assign phase_if.wrap       = wrap_w;
  assign phase_if.sweep_done = done_q;

endmodule

// File: tb/tb_sintable_phase_gen.sv
// Directed self-checking bench for sintable_phase_gen (PW=24, OW=8).
module tb_sintable_phase_gen;

  localparam int unsigned PW = 24;
  localparam int unsigned OW = 8;

  typedef struct {
    logic          ce;
    logic          start;
    logic          stop;
    logic          chk_ph;
    logic [OW-1:0] ph;
    logic          v;
    logic          w;
    logic          d;
    logic          b;
  } vec_t;

  logic          clk;
  logic          i_reset, i_ce, i_cfg_wr, i_start, i_stop;
  logic [1:0]    i_cfg_addr;
  logic [PW-1:0] i_cfg_data;
  logic          o_busy;

  int n_tests;
  int n_fail;
  vec_t vecs[$];

  sintable_phase_gen_if #(.OW(OW)) ph_if ();

  sintable_phase_gen #(.PW(PW), .OW(OW)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_ce       (i_ce),
    .i_cfg_wr   (i_cfg_wr),
    .i_cfg_addr (i_cfg_addr),
    .i_cfg_data (i_cfg_data),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .phase_if   (ph_if),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic chk_ph, input logic [OW-1:0] ph,
                         input logic v, input logic w, input logic d, input logic b);
    if (chk_ph) chk({name, ".phase"}, 32'(ph_if.phase), 32'(ph));
    chk({name, ".valid"}, 32'(ph_if.valid), 32'(v));
    chk({name, ".wrap"}, 32'(ph_if.wrap), 32'(w));
    chk({name, ".done"}, 32'(ph_if.sweep_done), 32'(d));
    chk({name, ".busy"}, 32'(o_busy), 32'(b));
  endtask

  task automatic cfg(input logic [1:0] addr, input logic [PW-1:0] data);
    i_cfg_wr   = 1'b1;
    i_cfg_addr = addr;
    i_cfg_data = data;
    tick();
    i_cfg_wr   = 1'b0;
  endtask

  function automatic vec_t mk(input logic ce, input logic st, input logic sp, input logic cp,
                              input logic [OW-1:0] ph, input logic v, input logic w,
                              input logic d, input logic b);
    vec_t r;
    r.ce = ce; r.start = st; r.stop = sp; r.chk_ph = cp;
    r.ph = ph; r.v = v; r.w = w; r.d = d; r.b = b;
    return r;
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    i_reset = 1'b1; i_ce = 1'b1; i_start = 1'b1; i_stop = 1'b0;
    i_cfg_wr = 1'b0; i_cfg_addr = 2'd0; i_cfg_data = '0;

    // 1. Reset held with ce and start asserted.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("reset%0d", i), 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    i_reset = 1'b0; i_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("idle_ce%0d", i), 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    i_ce = 1'b0;

    // 2. Tone with full wrap.
    cfg(2'd0, 24'h010000);
    i_start = 1'b1; tick(); i_start = 1'b0;
    chk_all("tone_start", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    i_ce = 1'b1;
    for (int k = 0; k < 257; k++) begin
      tick();
      chk_all($sformatf("tone%0d", k), 1'b1, OW'(k), 1'b1, (k == 255), 1'b0, 1'b1);
    end
    i_ce = 1'b0; tick();
    chk_all("tone_noce", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // 3. Phase offset, changed mid-run.
    cfg(2'd3, 24'h400000);
    cfg(2'd0, 24'h020000);
    i_start = 1'b1; tick(); i_start = 1'b0;
    i_ce = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all($sformatf("ofs%0d", k), 1'b1, OW'(8'h40 + 2 * k), 1'b1, 1'b0, 1'b0, 1'b1);
    end
    i_ce = 1'b0;
    cfg(2'd3, 24'h000000);
    i_ce = 1'b1; tick(); i_ce = 1'b0;
    chk_all("ofs_drop", 1'b1, 8'h06, 1'b1, 1'b0, 1'b0, 1'b1);

    // 4/5. Chirp, stop, start+stop, restart (table driven).
    cfg(2'd0, 24'h010000);
    cfg(2'd2, 24'h010000);
    cfg(2'd1, 24'h040000);
    //              ce  st  sp  cp  ph     v  w  d  b
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 8'h00, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 8'h01, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 8'h03, 1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0, 1, 8'h06, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 8'h0A, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 8'h0E, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 8'h00, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 8'h01, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 8'h03, 1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 1, 1, 8'h03, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'h03, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 8'h03, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'h03, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 8'h00, 1, 0, 0, 1));
    for (int i = 0; i < vecs.size(); i++) begin
      i_ce = vecs[i].ce; i_start = vecs[i].start; i_stop = vecs[i].stop;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].chk_ph, vecs[i].ph,
              vecs[i].v, vecs[i].w, vecs[i].d, vecs[i].b);
    end
    i_ce = 1'b0; i_start = 1'b0; i_stop = 1'b0;

    // 6. Reset in the middle of a sweep.
    i_start = 1'b1; tick(); i_start = 1'b0;
    i_ce = 1'b1; tick(); tick();
    i_reset = 1'b1; tick();
    chk_all("rst_sweep", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    i_reset = 1'b0; tick();
    chk_all("rst_idle", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    i_ce = 1'b0;
    // Cleared FSTART/FSTEP/FSTOP/POFS give a stationary TONE at phase 0.
    i_start = 1'b1; tick(); i_start = 1'b0;
    i_ce = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk_all($sformatf("rst_tone%0d", k), 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    i_ce = 1'b0; tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sintable_phase_gen.md
Name: sintable_phase_gen

Overview:
Numerically controlled phase generator that drives the phase input of the sintable lookup. It is the producer end of the sintable phase interface. It accumulates a programmable frequency word, with an optional linear chirp, on each sample strobe. It emits the top OW bits of (accumulator + phase offset) as the table address, with a one-cycle valid strobe.

Parameters:
PW, 24, accumulator, frequency-word and offset width (bits)
OW, 8, output phase width; equals the sintable address width

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_reset  in  1  synchronous reset, active-high
i_ce  in  1  sample strobe; one accumulator step per asserted cycle
i_cfg_wr  in  1  configuration register write enable
i_cfg_addr  in  2  register select: 0 = FSTART, 1 = FSTOP, 2 = FSTEP, 3 = POFS
i_cfg_data  in  PW  register write data
i_start  in  1  start or restart generation
i_stop  in  1  halt generation
o_phase  out  OW  phase address to sintable
o_valid  out  1  o_phase valid, one-cycle pulse per accepted i_ce
o_wrap  out  1  accumulator carry-out for the emitted sample, qualified by o_valid
o_sweep_done  out  1  one-cycle pulse when the chirp reaches FSTOP
o_busy  out  1  high in TONE or SWEEP

Behaviour:
- Reset:
  - state = IDLE.
  - acc, freq, FSTART, FSTOP, FSTEP, POFS = 0.
  - o_phase = 0; o_valid, o_wrap, o_sweep_done, o_busy = 0.
- Config writes:
  - Register is updated at the clock edge; accepted in every state.
  - FSTOP, FSTEP and POFS take effect from the next i_ce.
  - FSTART is sampled only on i_start.
- States: IDLE, TONE, SWEEP.
- i_start (any state):
  - acc <= 0; freq <= FSTART.
  - Next state = SWEEP if FSTEP != 0 and FSTART < FSTOP (unsigned), else TONE.
  - A restart while busy discards the running phase.
- i_stop: next state = IDLE. freq and acc hold; o_phase holds its last value.
- i_stop and i_start in the same cycle: stop wins.
- i_ce is ignored in IDLE and in any cycle where i_start or i_stop is asserted.
- On i_ce in TONE or SWEEP:
  - sum = acc + POFS, modulo 2^PW.
  - o_phase <= sum[PW-1:PW-OW].
  - o_valid <= 1.
  - {o_wrap, acc} <= acc + freq, i.e. o_wrap is the (PW+1)-bit carry.
  - Latency: the first sample after start emits POFS[PW-1:PW-OW], i.e. the phase before any increment.
- SWEEP, per i_ce:
  - nf = freq + FSTEP, computed PW+1 wide.
  - If nf >= FSTOP: freq <= FSTOP, state <= TONE, and o_sweep_done = 1 in the same cycle as this sample's o_valid.
  - Otherwise freq <= nf.
  - The emitted sample always uses the old freq.
- o_valid, o_wrap and o_sweep_done are zero in every cycle without an accepted i_ce.
- o_busy is registered; it equals (state != IDLE).
- Accumulator overflow wraps modulo 2^PW; no saturation anywhere except the sweep clamp to FSTOP.

Decomposition:
- Package sintable_pkg:
  - Register address constants REG_FSTART, REG_FSTOP, REG_FSTEP, REG_POFS.
  - State encoding constants ST_IDLE, ST_TONE, ST_SWEEP.
  - Default PW and OW.
- One sub-module, sintable_phase_acc:
  - Contents: the PW-bit accumulator with carry, the offset add and the OW-bit truncation register.
  - The FSM, config registers and sweep logic stay in the top module.

Test Plan:
All scenarios use PW=24, OW=8.
1. Reset: hold i_reset 3 cycles with i_ce=1 and i_start=1 -> all outputs 0, o_busy=0; after release with no start, i_ce pulses give o_valid=0.
2. Tone: FSTART=0x010000, FSTEP=0, i_start, then i_ce every cycle -> o_phase 0x00, 0x01, 0x02, ...; the 256th sample is 0xFF with o_wrap=1; the next sample is 0x00.
3. Offset: POFS=0x400000, FSTART=0x020000, start -> o_phase 0x40, 0x42, 0x44; writing POFS=0 mid-run -> the next sample drops by 0x40.
4. Chirp: FSTART=0x010000, FSTEP=0x010000, FSTOP=0x040000 -> o_phase 0x00, 0x01, 0x03 (o_sweep_done=1), 0x06, 0x0A, 0x0E; o_busy stays 1.
5. Stop and restart: stop after sample 0x03 -> o_valid=0 and o_busy=0 next cycle, o_phase holds 0x03; i_start together with i_stop -> stays IDLE; i_start alone -> first sample 0x00.
6. Reset mid-sweep: assert i_reset during SWEEP -> next cycle IDLE, all registers and outputs 0; no o_sweep_done pulse.
